regfile_ctrl: RTL
=================

# regfile_ctrl

Command sequencer that drives the write port and both read ports of the 16×16-bit `register_file`. It accepts one register-to-register command at a time over a valid/ready handshake and executes it as a fixed read/write cycle sequence. Supported commands are MOV, ADD, SWAP and FILL. It sits between the control logic and `register_file`, and is the only agent driving the file's address, write-data and write-enable inputs.

## Interface
Parameters:
- `AW`, 4: register address width (16 registers)
- `DW`, 16: data width

Ports:
- `clk`  in  1  clock; all state on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `cmd_valid`  in  1  command present
- `cmd_ready`  out  1  controller idle, can accept
- `cmd_op`  in  2  00 MOV, 01 ADD, 10 SWAP, 11 FILL
- `cmd_rd`  in  AW  destination (MOV/ADD only)
- `cmd_rs1`  in  AW  source 1 / FILL start
- `cmd_rs2`  in  AW  source 2 / FILL end
- `cmd_imm`  in  DW  FILL value
- `done`  out  1  one-cycle pulse: command complete
- `busy`  out  1  command in progress
- `raddr1`, `raddr2`  out  AW  to register_file
- `rdata1`, `rdata2`  in  DW  from register_file, combinational on raddr
- `waddr`  out  AW  to register_file
- `wdata`  out  DW  to register_file
- `wen`  out  1  to register_file; the file writes on the rising edge while high

## Operation
- All outputs are registered.
- Reset values: `cmd_ready`=1; `done`, `busy`, `wen`=0; all address and data outputs 0.
- States: IDLE, RD, WR1, WR2, FILL.
- IDLE:
  - `cmd_ready`=1.
  - On `cmd_valid & cmd_ready`, latch all cmd fields.
  - Drive `raddr1`=rs1 and `raddr2`=rs2.
  - Go to FILL for op 11, otherwise to RD.
- RD: sample `rdata1`/`rdata2` into temps t1/t2.
  - MOV: waddr=rd, wdata=t1.
  - ADD: waddr=rd, wdata=(t1+t2) mod 2^16, carry discarded.
  - SWAP: waddr=rs1, wdata=t2.
  - In all three cases wen=1 and the next state is WR1.
- WR1:
  - MOV/ADD: go to IDLE with wen=0 and done=1.
  - SWAP: waddr=rs2, wdata=t1, wen=1, go to WR2.
- WR2: go to IDLE with wen=0 and done=1.
- FILL:
  - wen=1 and wdata=imm every cycle.
  - waddr starts at rs1 and increments mod 16, wrapping 15→0.
  - The last write is at waddr==rs2, so (rs2−rs1) mod 16 + 1 writes occur; rs1==rs2 gives one write.
  - On the next edge: go to IDLE with wen=0 and done=1.
- `busy` is high in every state except IDLE. `cmd_ready` equals !busy.
- Overlapping operands:
  - MOV/ADD with rd==rs1 or rd==rs2 use the pre-write values.
  - SWAP with rs1==rs2 leaves the register unchanged: two identical writes.
- Fields are latched, so `cmd_*` changes after acceptance have no effect.
- Reset asserted mid-command:
  - Outputs return to reset values immediately; wen drops asynchronously.
  - The command is abandoned; registers already written keep their new values.
  - done is not pulsed.

## Timing
- Accept edge = T0.
- MOV/ADD:
  - Read during T0–T1.
  - wen high T1–T2; the write lands at edge T2.
  - done high T2–T3; the next command can be accepted at edge T3.
- SWAP: writes land at edges T2 and T3; done T3–T4.
- FILL with N writes: writes land at edges T1..TN; done TN to TN+1.
- `done` and `cmd_ready` are high in the same cycle.
- A cmd_valid held continuously gives back-to-back commands with no idle gap beyond the done cycle.

## Configuration
- `REGFILE_CTRL_R0_ZERO_EN` defined: register 0 is hardwired zero.
  - Any write with waddr==0 is issued with wen=0. The cycle is still consumed, and done timing is unchanged.
  - Reads of address 0 use 0 in place of `rdata1`/`rdata2`.
- Undefined: register 0 is an ordinary register.

## Test plan
- Reset, then MOV, ADD, then SWAP:
  - Reset → cmd_ready=1, wen=0, done=0.
  - FILL rs1=4, rs2=4, imm=16'h2021, then MOV rd=5, rs1=4 → r5=16'h2021; done 2 cycles after the MOV accept edge.
  - ADD rd=6, rs1=4, rs2=5 with r4=16'hFFFF, r5=16'h0002 → r6=16'h0001.
  - SWAP rs1=4, rs2=5 with r4=16'h2021, r5=16'h5159 → r4=16'h5159, r5=16'h2021; done 3 cycles after accept.
- FILL wrap: rs1=14, rs2=1, imm=16'hA5A5 → r14, r15, r0, r1 written, 4 wen cycles; r2 and r13 unchanged.
- Reset mid-FILL: rs1=0, rs2=15, rst_n low after 3 writes → wen=0 at once; r0–r2 =imm, r3 unchanged; no done pulse; cmd_ready=1 after release.
- Back-to-back: cmd_valid held for 3 MOVs → accepts exactly 3 cycles apart; results correct in order.
- With `REGFILE_CTRL_R0_ZERO_EN`: FILL rs1=0, rs2=0, imm=16'h1234 → r0 stays 0 and wen stays low. MOV rd=3, rs1=0 → r3=0.

Source files
------------

// File: rtl/regfile_ctrl.sv
// Command sequencer driving the write port and both read ports of a 16x16 register file.
// Optional build macro REGFILE_CTRL_R0_ZERO_EN makes register 0 a hardwired zero.
module regfile_ctrl #(
   parameter int AW = 4,
   parameter int DW = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic [1:0]    cmd_op,
   input  logic [AW-1:0] cmd_rd,
   input  logic [AW-1:0] cmd_rs1,
   input  logic [AW-1:0] cmd_rs2,
   input  logic [DW-1:0] cmd_imm,
   output logic          done,
   output logic          busy,
   output logic [AW-1:0] raddr1,
   output logic [AW-1:0] raddr2,
   input  logic [DW-1:0] rdata1,
   input  logic [DW-1:0] rdata2,
   output logic [AW-1:0] waddr,
   output logic [DW-1:0] wdata,
   output logic          wen,
   output logic [2:0]    dbg_state
);

   // Handshake: a command is taken on the rising edge where cmd_valid and
   // cmd_ready are both high; cmd_ready stays low until the done cycle.
   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_RD   = 3'd1,
      S_WR1  = 3'd2,
      S_WR2  = 3'd3,
      S_FILL = 3'd4
   } state_t;

   localparam logic [1:0] OP_MOV  = 2'b00;
   localparam logic [1:0] OP_ADD  = 2'b01;
   localparam logic [1:0] OP_SWAP = 2'b10;
   localparam logic [1:0] OP_FILL = 2'b11;

   state_t        state_q, state_d;
   logic [1:0]    op_q, op_d;
   logic [AW-1:0] rd_q, rd_d;
   logic [AW-1:0] raddr1_q, raddr1_d;
   logic [AW-1:0] raddr2_q, raddr2_d;
   logic [AW-1:0] waddr_q, waddr_d;
   logic [DW-1:0] wdata_q, wdata_d;
   logic [DW-1:0] t1_q, t1_d;
   logic          wen_q, wen_d, wen_req;
   logic          done_q, done_d;
   logic          busy_q, busy_d;
   logic          ready_q, ready_d;
   logic [DW-1:0] rd1, rd2;

`ifdef REGFILE_CTRL_R0_ZERO_EN
   // Register 0 reads as zero and is never written; the write cycle is still spent.
   assign rd1   = (raddr1_q == '0) ? '0 : rdata1;
   assign rd2   = (raddr2_q == '0) ? '0 : rdata2;
   assign wen_d = wen_req & (waddr_d != '0);
`else
   assign rd1   = rdata1;
   assign rd2   = rdata2;
   assign wen_d = wen_req;
`endif

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      rd_d     = rd_q;
      raddr1_d = raddr1_q;
      raddr2_d = raddr2_q;
      waddr_d  = waddr_q;
      wdata_d  = wdata_q;
      t1_d     = t1_q;
      wen_req  = 1'b0;
      done_d   = 1'b0;
      busy_d   = busy_q;
      ready_d  = ready_q;
      case (state_q)
         S_IDLE: begin
            if (cmd_valid && ready_q) begin
               op_d     = cmd_op;
               rd_d     = cmd_rd;
               raddr1_d = cmd_rs1;
               raddr2_d = cmd_rs2;
               busy_d   = 1'b1;
               ready_d  = 1'b0;
               if (cmd_op == OP_FILL) begin
                  // First fill write is issued straight from the accept edge.
                  waddr_d = cmd_rs1;
                  wdata_d = cmd_imm;
                  wen_req = 1'b1;
                  state_d = S_FILL;
               end else begin
                  state_d = S_RD;
               end
            end
         end
         S_RD: begin
            t1_d    = rd1;
            wen_req = 1'b1;
            state_d = S_WR1;
            case (op_q)
               OP_ADD: begin
                  waddr_d = rd_q;
                  wdata_d = rd1 + rd2;
               end
               OP_SWAP: begin
                  waddr_d = raddr1_q;
                  wdata_d = rd2;
               end
               default: begin
                  waddr_d = rd_q;
                  wdata_d = rd1;
               end
            endcase
         end
         S_WR1: begin
            if (op_q == OP_SWAP) begin
               waddr_d = raddr2_q;
               wdata_d = t1_q;
               wen_req = 1'b1;
               state_d = S_WR2;
            end else begin
               done_d  = 1'b1;
               busy_d  = 1'b0;
               ready_d = 1'b1;
               state_d = S_IDLE;
            end
         end
         S_WR2: begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            ready_d = 1'b1;
            state_d = S_IDLE;
         end
         S_FILL: begin
            if (waddr_q == raddr2_q) begin
               done_d  = 1'b1;
               busy_d  = 1'b0;
               ready_d = 1'b1;
               state_d = S_IDLE;
            end else begin
               waddr_d = waddr_q + 1'b1;
               wen_req = 1'b1;
            end
         end
         default: begin
            busy_d  = 1'b0;
            ready_d = 1'b1;
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         op_q     <= '0;
         rd_q     <= '0;
         raddr1_q <= '0;
         raddr2_q <= '0;
         waddr_q  <= '0;
         wdata_q  <= '0;
         t1_q     <= '0;
         wen_q    <= 1'b0;
         done_q   <= 1'b0;
         busy_q   <= 1'b0;
         ready_q  <= 1'b1;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         rd_q     <= rd_d;
         raddr1_q <= raddr1_d;
         raddr2_q <= raddr2_d;
         waddr_q  <= waddr_d;
         wdata_q  <= wdata_d;
         t1_q     <= t1_d;
         wen_q    <= wen_d;
         done_q   <= done_d;
         busy_q   <= busy_d;
         ready_q  <= ready_d;
      end
   end

   assign cmd_ready = ready_q;
   assign done      = done_q;
   assign busy      = busy_q;
   assign raddr1    = raddr1_q;
   assign raddr2    = raddr2_q;
   assign waddr     = waddr_q;
   assign wdata     = wdata_q;
   assign wen       = wen_q;
   assign dbg_state = state_q;

endmodule
